// File: rtl/mem_io_bridge_pkg.sv
// Shared address map and read-select encoding for the cpu-side memory/I/O bridge.
package mem_io_bridge_pkg;

  localparam logic [17:0] IO_BASE    = 18'h30000;
  localparam logic [2:0]  IO_CNT_OFS = 3'h4;
  localparam logic [17:0] IO_CNT     = IO_BASE + {15'd0, IO_CNT_OFS};

  typedef enum logic [1:0] {
    RD_SEL_RAM  = 2'd0,
    RD_SEL_RX   = 2'd1,
    RD_SEL_CNT  = 2'd2,
    RD_SEL_ZERO = 2'd3
  } rd_sel_e;

endpackage

// File: rtl/mem_io_bridge_io_tx_skid.sv
// One-entry skid in front of the UART tx FIFO: direct push when possible,
// otherwise park the byte; a parked byte drains before any new write.
module mem_io_bridge_io_tx_skid (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_data,
  output logic       io_buffer_full
);

  logic       skid_vld;
  logic [7:0] skid_data;
  logic       drain, direct, take, skid_vld_nxt;

  always_comb begin
    drain        = skid_vld & ~tx_full;
    direct       = wr_en & ~skid_vld & ~tx_full;
    // A write may refill the skid in the same cycle it drains.
    take         = wr_en & ~direct & (~skid_vld | drain);
    skid_vld_nxt = (skid_vld & ~drain) | take;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      tx_push        <= 1'b0;
      tx_data        <= 8'h00;
      skid_vld       <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      tx_push        <= drain | direct;
      if (drain)       tx_data <= skid_data;
      else if (direct) tx_data <= wr_data;
      skid_vld       <= skid_vld_nxt;
      io_buffer_full <= tx_full | skid_vld_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (take) skid_data <= wr_data;
  end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU byte-bus bridge: RAM/I/O decode, 1-cycle read return, cycle counter,
// UART rx pop and tx push via a skid buffer.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int RAM_AW = 17,
  parameter int CNT_W  = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [31:0]       cpu_a,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_din,
  output logic              io_buffer_full,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_push,
  input  logic              tx_full,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty,
  output logic              rx_pop,
  output logic              program_stop
);

  logic [17:0] a18;
  logic        io, at_base, at_cnt0, in_cnt, rd_req;
  logic        tx_wr_en;
  logic [7:0]  tx_wr_data;
  logic        unused_hi;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_snap_p1;
  rd_sel_e          rd_sel_p1;
  logic [1:0]       rd_idx_p1;
  logic [7:0]       rx_byte_p1;

  assign a18       = cpu_a[17:0];
  assign unused_hi = ^cpu_a[31:18];
  assign io        = (cpu_a[17:16] == 2'b11) & rdy_in;
  assign at_base   = (a18 == IO_BASE);
  assign at_cnt0   = (a18 == IO_CNT);
  assign in_cnt    = (a18[17:2] == IO_CNT[17:2]);
  assign rd_req    = rdy_in & ~cpu_wr;

  assign ram_a     = cpu_a[RAM_AW-1:0];
  assign ram_we    = rst_in & cpu_wr & ~io & rdy_in;
  assign ram_wdata = cpu_dout;
  assign rx_pop    = rst_in & io & ~cpu_wr & at_base & ~rx_empty;

  // Writing the stop register also sends a 0x00 marker byte to the UART.
  assign tx_wr_en   = io & cpu_wr & ((at_base & (cpu_dout != 8'h00)) | at_cnt0);
  assign tx_wr_data = at_cnt0 ? 8'h00 : cpu_dout;

  // Stage p1: request-cycle capture of read source, byte index and data
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt          <= '0;
      cnt_snap_p1  <= '0;
      rd_sel_p1    <= RD_SEL_RAM;
      rd_idx_p1    <= 2'd0;
      rx_byte_p1   <= 8'h00;
      program_stop <= 1'b0;
    end else begin
      if (!program_stop) cnt <= cnt + CNT_W'(1);
      if (io & cpu_wr & at_cnt0) program_stop <= 1'b1;
      if (rd_req) begin
        rd_idx_p1 <= cpu_a[1:0];
        if (!io) begin
          rd_sel_p1 <= RD_SEL_RAM;
        end else if (at_base && !rx_empty) begin
          rd_sel_p1  <= RD_SEL_RX;
          rx_byte_p1 <= rx_data;
        end else if (in_cnt) begin
          rd_sel_p1 <= RD_SEL_CNT;
          // Byte 0 freezes the snapshot so a 4-byte read is coherent.
          if (cpu_a[1:0] == 2'd0) cnt_snap_p1 <= cnt;
        end else begin
          rd_sel_p1 <= RD_SEL_ZERO;
        end
      end
    end
  end

  always_comb begin
    cpu_din = 8'h00;
    case (rd_sel_p1)
      RD_SEL_RAM: cpu_din = ram_rdata;
      RD_SEL_RX:  cpu_din = rx_byte_p1;
      RD_SEL_CNT: cpu_din = cnt_snap_p1[{rd_idx_p1, 3'b000} +: 8];
      default:    cpu_din = 8'h00;
    endcase
  end

  mem_io_bridge_io_tx_skid u_tx_skid (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .wr_en          (tx_wr_en),
    .wr_data        (tx_wr_data),
    .tx_full        (tx_full),
    .tx_push        (tx_push),
    .tx_data        (tx_data),
    .io_buffer_full (io_buffer_full)
  );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Randomised bench for mem_io_bridge with a queue-based reference model and directed literal checks.
module tb_mem_io_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, cpu_wr, tx_full, rx_empty;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout, ram_rdata, rx_data;
  logic [7:0]  cpu_din, ram_wdata, tx_data;
  logic [16:0] ram_a;
  logic        io_buffer_full, ram_we, tx_push, rx_pop, program_stop;

  always #5 clk_in = ~clk_in;

  mem_io_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .cpu_a(cpu_a),
    .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .tx_data(tx_data),
    .tx_push(tx_push), .tx_full(tx_full), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_pop(rx_pop), .program_stop(program_stop)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: memory array, byte queue for the skid, plain counters.
  logic [7:0]  mem [0:131071];
  bit          model_ok = 1'b0;
  int unsigned m_cnt, m_snap;
  bit          m_ps;
  logic [7:0]  skid_q [$];
  bit          e_push, e_ibf, chk_din;
  logic [7:0]  e_tdata, e_din;

  logic [17:0] ma;
  bit          mio, mwv, mpushed;
  logic [7:0]  mwb;

  always @(posedge clk_in) begin
    ma = cpu_a[17:0];
    ram_rdata <= mem[cpu_a[16:0]];
    if (!rst_in) begin
      model_ok = 1'b1;
      chk_din  = 1'b0;
      m_cnt    = 0;
      m_snap   = 0;
      m_ps     = 1'b0;
      skid_q.delete();
      e_push   = 1'b0;
      e_tdata  = 8'h00;
      e_ibf    = 1'b0;
    end else begin
      mio     = (ma[17:16] == 2'b11) && rdy_in;
      chk_din = rdy_in && !cpu_wr;
      if (chk_din) begin
        if (!mio)                          e_din = mem[ma[16:0]];
        else if (ma == 18'h30000)          e_din = rx_empty ? 8'h00 : rx_data;
        else if (ma[17:2] == 16'hC001) begin
          if (ma[1:0] == 2'd0) m_snap = m_cnt;
          e_din = 8'(m_snap >> (8 * ma[1:0]));
        end else                           e_din = 8'h00;
      end
      if (rdy_in && cpu_wr && !mio) mem[ma[16:0]] = cpu_dout;
      mwv = mio && cpu_wr && ((ma == 18'h30000 && cpu_dout != 8'h00) || ma == 18'h30004);
      mwb = (ma == 18'h30004) ? 8'h00 : cpu_dout;
      mpushed = 1'b0;
      if (skid_q.size() > 0 && !tx_full) begin
        e_tdata = skid_q.pop_front();
        mpushed = 1'b1;
      end
      if (mwv) begin
        if (skid_q.size() == 0 && !mpushed && !tx_full) begin
          e_tdata = mwb;
          mpushed = 1'b1;
        end else if (skid_q.size() == 0) begin
          skid_q.push_back(mwb);
        end
      end
      e_push = mpushed;
      e_ibf  = tx_full || (skid_q.size() > 0);
      if (!m_ps) m_cnt++;
      if (mio && cpu_wr && ma == 18'h30004) m_ps = 1'b1;
    end
  end

  // Compare process: mid-cycle, away from the active edge.
  bit exp_we, exp_pop;
  always @(negedge clk_in) begin
    if (model_ok) begin
      exp_we  = rst_in && rdy_in && cpu_wr && (cpu_a[17:16] != 2'b11);
      exp_pop = rst_in && rdy_in && !cpu_wr && (cpu_a[17:0] == 18'h30000) && !rx_empty;
      chk("ram_a", 32'(ram_a), 32'(cpu_a[16:0]));
      chk("ram_we", 32'(ram_we), 32'(exp_we));
      if (exp_we) chk("ram_wdata", 32'(ram_wdata), 32'(cpu_dout));
      chk("rx_pop", 32'(rx_pop), 32'(exp_pop));
      chk("tx_push", 32'(tx_push), 32'(e_push));
      if (e_push) chk("tx_data", 32'(tx_data), 32'(e_tdata));
      chk("io_buffer_full", 32'(io_buffer_full), 32'(e_ibf));
      chk("program_stop", 32'(program_stop), 32'(m_ps));
      if (chk_din) chk("cpu_din", 32'(cpu_din), 32'(e_din));
    end
  end

  task automatic cyc(input bit rst, input bit rdy, input logic [31:0] a, input bit wr,
                     input logic [7:0] d, input bit txf, input logic [7:0] rxd, input bit rxe);
    @(posedge clk_in);
    #1;
    rst_in = rst; rdy_in = rdy; cpu_a = a; cpu_wr = wr; cpu_dout = d;
    tx_full = txf; rx_data = rxd; rx_empty = rxe;
    #1;
  endtask

  task automatic idle(input bit txf);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 8'h00, txf, 8'h00, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_din"}, 32'(cpu_din), 32'h0);
    chk({tag, "_tx_push"}, 32'(tx_push), 32'h0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    chk({tag, "_ibf"}, 32'(io_buffer_full), 32'h0);
    chk({tag, "_stop"}, 32'(program_stop), 32'h0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'h0);
    chk({tag, "_rx_pop"}, 32'(rx_pop), 32'h0);
  endtask

  logic [31:0] ra, hi;
  bit          rwr;

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom());
    mem[0]     = 8'h00;
    mem[17'h10] = 8'hA5;
    rst_in = 1'b0; rdy_in = 1'b0; cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
    tx_full = 1'b0; rx_data = 8'h00; rx_empty = 1'b1; ram_rdata = 8'h00;

    cyc(1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(1'b0);
    chk_all_zero("reset");

    // RAM read, plus upper address bits ignored
    cyc(1'b1, 1'b1, 32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t1_ram_we", 32'(ram_we), 32'h0);
    idle(1'b0);
    chk("t1_din", 32'(cpu_din), 32'hA5);
    cyc(1'b1, 1'b1, 32'hFFFC_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(1'b0);
    chk("t1_din_hi", 32'(cpu_din), 32'hA5);

    // tx direct push and ignored zero byte
    cyc(1'b1, 1'b1, 32'h0003_0000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
    idle(1'b0);
    chk("t2_push", 32'(tx_push), 32'h1);
    chk("t2_data", 32'(tx_data), 32'h41);
    cyc(1'b1, 1'b1, 32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(1'b0);
    chk("t2_zero_push", 32'(tx_push), 32'h0);

    // tx blocked into skid, then drained
    cyc(1'b1, 1'b1, 32'h0003_0000, 1'b1, 8'h42, 1'b1, 8'h00, 1'b1);
    idle(1'b1);
    chk("t3_ibf", 32'(io_buffer_full), 32'h1);
    chk("t3_nopush", 32'(tx_push), 32'h0);
    idle(1'b0);
    idle(1'b0);
    chk("t3_push", 32'(tx_push), 32'h1);
    chk("t3_data", 32'(tx_data), 32'h42);
    chk("t3_ibf_clr", 32'(io_buffer_full), 32'h0);
    idle(1'b0);
    chk("t3_single", 32'(tx_push), 32'h0);

    // rx read, empty and non-empty
    cyc(1'b1, 1'b1, 32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h7A, 1'b1);
    chk("t5_nopop", 32'(rx_pop), 32'h0);
    idle(1'b0);
    chk("t5_empty_din", 32'(cpu_din), 32'h00);
    cyc(1'b1, 1'b1, 32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h7A, 1'b0);
    chk("t5_pop", 32'(rx_pop), 32'h1);
    idle(1'b0);
    chk("t5_pop_once", 32'(rx_pop), 32'h0);
    chk("t5_din", 32'(cpu_din), 32'h7A);

    // Coherent counter snapshot at 0x1FF
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 32'h1FF; i++) idle(1'b0);
    cyc(1'b1, 1'b1, 32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b1, 32'h0003_0005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t4_b0", 32'(cpu_din), 32'hFF);
    cyc(1'b1, 1'b1, 32'h0003_0006, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t4_b1", 32'(cpu_din), 32'h01);
    cyc(1'b1, 1'b1, 32'h0003_0007, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t4_b2", 32'(cpu_din), 32'h00);
    idle(1'b0);
    chk("t4_b3", 32'(cpu_din), 32'h00);

    // program_stop, marker byte, frozen counter, then reset
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b0);
    cyc(1'b1, 1'b1, 32'h0003_0004, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    idle(1'b0);
    chk("t6_stop", 32'(program_stop), 32'h1);
    chk("t6_push", 32'(tx_push), 32'h1);
    chk("t6_data", 32'(tx_data), 32'h00);
    for (int i = 0; i < 3; i++) idle(1'b0);
    cyc(1'b1, 1'b1, 32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(1'b0);
    chk("t6_frozen", 32'(cpu_din), 32'h06);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(1'b0);
    chk_all_zero("t6_reset");
    idle(1'b0);
    idle(1'b0);
    cyc(1'b1, 1'b1, 32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(1'b0);
    chk("t6_cnt_restart", 32'(cpu_din), 32'h03);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      hi  = $urandom();
      rwr = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          ra = 32'($urandom_range(1, 17'h1FFFF));
          cpu_a = {hi[31:18], 1'b0, ra[16:0]};
        end
        5:       cpu_a = {hi[31:18], 18'h30000};
        6, 7: begin
          ra = 32'($urandom_range(4, 7));
          cpu_a = {hi[31:18], 18'h30000 | ra[17:0]};
          if (ra == 32'd4 && $urandom_range(0, 19) != 0) rwr = 1'b0;
        end
        default: begin
          ra = 32'($urandom_range(8, 16'hFFFF));
          cpu_a = {hi[31:18], 2'b11, ra[15:0]};
        end
      endcase
      ra = $urandom();
      cyc($urandom_range(0, 399) != 0, $urandom_range(0, 6) != 0, cpu_a, rwr,
          ($urandom_range(0, 3) == 0) ? 8'h00 : ra[7:0],
          $urandom_range(0, 2) == 0, ra[15:8], $urandom_range(0, 1) == 1);
    end
    idle(1'b0);
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
